// File: rtl/compc_iter_if.sv
// compc_iter_if: start/result bundle between the ALU control FSM and the
// sequential comparator.
//   master (ALU control): drives enable, data_in {A,B}, mode; reads results
//   slave  (comparator) : reads start/operands; drives busy, ab_out, done_compc
interface compc_iter_if #(parameter int WIDTH = 8);
  logic               enable;
  logic [2*WIDTH-1:0] data_in;
  logic               mode;
  logic               busy;
  logic [3:0]         ab_out;
  logic               done_compc;

  modport master (output enable, data_in, mode, input busy, ab_out, done_compc);
  modport slave  (input enable, data_in, mode, output busy, ab_out, done_compc);
endinterface

// File: rtl/compc_iter.sv
// compc_iter: sequential magnitude comparator. Captures A/B on enable and
// scans MSB-first, STEP bits per clock. It stops at the first differing
// slice, or at slice 0 when the operands are equal.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   bus (slave)   enable/data_in/mode in; busy/ab_out/done_compc out
//                 ab_out = {early, gt, lt, eq}
// Optional macro COMPC_SIGNED_EN: mode=1 selects a signed comparison. Both
// MSBs are flipped at capture, so the unsigned scan orders two's complement
// values correctly. Without the macro, mode is ignored.
module compc_iter #(
  parameter int WIDTH = 8,
  parameter int STEP  = 2
) (
  input  logic         clk,
  input  logic         rst,
  compc_iter_if.slave  bus
);
  localparam int N  = WIDTH / STEP;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, a_cap, b_cap;
  logic [IW-1:0]     idx_q;
  logic [STEP-1:0]   sa, sb;
  logic              differ, last, decide;
  logic [3:0]        res;

  // Operand capture, with optional offset-binary conversion.
`ifdef COMPC_SIGNED_EN
  assign a_cap = bus.data_in[2*WIDTH-1:WIDTH] ^ {bus.mode, {(WIDTH-1){1'b0}}};
  assign b_cap = bus.data_in[WIDTH-1:0]       ^ {bus.mode, {(WIDTH-1){1'b0}}};
`else
  assign a_cap = bus.data_in[2*WIDTH-1:WIDTH];
  assign b_cap = bus.data_in[WIDTH-1:0];
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.enable) state_d = SCAN;
      SCAN: if (decide)     state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Output and slice-decision logic
  always_comb begin
    sa       = a_q[idx_q*STEP +: STEP];
    sb       = b_q[idx_q*STEP +: STEP];
    differ   = (sa != sb);
    last     = (idx_q == '0);
    bus.busy = (state_q == SCAN);
    decide   = (state_q == SCAN) && (differ || last);
    // A differing slice decides the result. A match at slice 0 means equal.
    res      = differ ? {!last, sa > sb, sa < sb, 1'b0} : 4'b0001;
  end

  // Datapath: operands, slice index, result and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q            <= '0;
      b_q            <= '0;
      idx_q          <= '0;
      bus.ab_out     <= 4'b0000;
      bus.done_compc <= 1'b0;
    end else begin
      bus.done_compc <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.enable) begin
          a_q   <= a_cap;
          b_q   <= b_cap;
          idx_q <= IW'(N - 1);
        end
      end else if (decide) begin
        bus.ab_out     <= res;
        bus.done_compc <= 1'b1;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_compc_iter.sv
module tb_compc_iter;
  localparam int WIDTH = 8;
  localparam int STEP  = 2;
  localparam int N     = WIDTH / STEP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  compc_iter_if #(.WIDTH(WIDTH)) bus ();
  compc_iter #(.WIDTH(WIDTH), .STEP(STEP)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One comparison from capture to done, with its latency and held result checked.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic m, input logic [3:0] exp_ab, input int exp_k);
    int  k;
    bit  got;
    bus.enable = 1'b1; bus.data_in = {a, b}; bus.mode = m;
    tick();  // E0
    bus.enable = 1'b0; bus.data_in = '0; bus.mode = 1'b0;
    chk({tag, " busy@E0"}, 32'(bus.busy), 32'd1);
    k = 0; got = 0;
    while (!got && k < N + 3) begin
      tick();
      k++;
      if (bus.done_compc) got = 1;
      else chk({tag, " busy mid"}, 32'(bus.busy), 32'd1);
    end
    chk({tag, " latency"}, 32'(k), 32'(exp_k));
    chk({tag, " done"}, 32'(got), 32'd1);
    chk({tag, " ab_out"}, 32'(bus.ab_out), 32'(exp_ab));
    chk({tag, " busy@done"}, 32'(bus.busy), 32'd0);
    tick();
    chk({tag, " done pulse"}, 32'(bus.done_compc), 32'd0);
    chk({tag, " ab hold"}, 32'(bus.ab_out), 32'(exp_ab));
  endtask

  initial begin
    bus.enable = 1'b0; bus.data_in = '0; bus.mode = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done_compc), 32'd0);
    chk("rst ab", 32'(bus.ab_out), 32'd0);

    run_op("eq5A",   8'h5A, 8'h5A, 1'b0, 4'b0001, 4);
    run_op("80v7Fu", 8'h80, 8'h7F, 1'b0, 4'b1100, 1);
`ifdef COMPC_SIGNED_EN
    run_op("80v7Fs", 8'h80, 8'h7F, 1'b1, 4'b1010, 1);
    run_op("FFv01s", 8'hFF, 8'h01, 1'b1, 4'b1010, 1);
`else
    run_op("80v7Fs", 8'h80, 8'h7F, 1'b1, 4'b1100, 1);
    run_op("FFv01s", 8'hFF, 8'h01, 1'b1, 4'b1100, 1);
`endif
    run_op("03v02",  8'h03, 8'h02, 1'b0, 4'b0100, 4);
    run_op("12v34",  8'h12, 8'h34, 1'b0, 4'b1010, 2);

    // Enable held high through a scan while the operands change to zero.
    bus.enable = 1'b1; bus.data_in = 16'h0302; bus.mode = 1'b0;
    tick();  // E0
    bus.data_in = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold busy", 32'(bus.busy), 32'd1);
      chk("hold nodone", 32'(bus.done_compc), 32'd0);
    end
    tick();  // E4
    chk("hold done", 32'(bus.done_compc), 32'd1);
    chk("hold ab", 32'(bus.ab_out), 32'h4);
    chk("hold busy@done", 32'(bus.busy), 32'd0);
    tick();  // E0 of back-to-back op (0 vs 0)
    bus.enable = 1'b0;
    chk("b2b busy", 32'(bus.busy), 32'd1);
    chk("b2b done low", 32'(bus.done_compc), 32'd0);
    chk("b2b ab kept", 32'(bus.ab_out), 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b2b nodone", 32'(bus.done_compc), 32'd0);
    end
    tick();
    chk("b2b done", 32'(bus.done_compc), 32'd1);
    chk("b2b ab", 32'(bus.ab_out), 32'h1);
    tick();

    // Reset in the middle of a scan aborts it.
    bus.enable = 1'b1; bus.data_in = 16'h0001;
    tick();  // E0
    bus.enable = 1'b0; bus.data_in = '0;
    tick();  // E1
    rst = 1'b1;
    tick();  // E2 with reset
    rst = 1'b0;
    chk("mrst busy", 32'(bus.busy), 32'd0);
    chk("mrst ab", 32'(bus.ab_out), 32'd0);
    chk("mrst done", 32'(bus.done_compc), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst nodone", 32'(bus.done_compc), 32'd0);
      chk("mrst idle", 32'(bus.busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/compc_iter.md
# compc_iter

Parametrised sequential magnitude comparator; successor of the 4-bit single-shot comparator in the ALU comparison path. Captures two WIDTH-bit operands on an `enable` pulse and scans them MSB-first, STEP bits per clock. Terminates as soon as the result is decided and reports equal/less/greater plus an early-exit flag with a one-cycle `done_compc` pulse. Sits beside the other ALU operation modules and is started and polled by the ALU control FSM.

## Interface
- `WIDTH`, default 8: operand width in bits; WIDTH ≥ 2.
- `STEP`, default 2: bits compared per cycle; must divide WIDTH. N = WIDTH/STEP slices.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `enable`  in  1  start request; sampled only in IDLE.
- `data_in`  in  2*WIDTH  operands: A = `data_in[2*WIDTH-1:WIDTH]`, B = `data_in[WIDTH-1:0]`.
- `mode`  in  1  0 = unsigned, 1 = signed two's complement; sampled with `enable`.
- `busy`  out  1  high while a comparison is in progress.
- `ab_out`  out  4  result: [0] A==B, [1] A<B, [2] A>B, [3] early exit.
- `done_compc`  out  1  one-cycle pulse when `ab_out` is updated.

## Operation
- States: IDLE, SCAN.
- IDLE, `enable`=1: register A, B, mode; slice index idx ← N-1; go to SCAN; `busy` ← 1.
- Signed handling: at capture, when signed mode is active, invert the MSB of both A and B (offset-binary). The scan itself is then always unsigned.
- SCAN: compare slice idx of A and B (bits idx*STEP+STEP-1 down to idx*STEP).
  - Slices differ: `ab_out` ← {idx≠0, A>B, A<B, 0}; `done_compc` ← 1; `busy` ← 0; go to IDLE.
  - Slices equal and idx==0: `ab_out` ← 4'b0001; `done_compc` ← 1; `busy` ← 0; go to IDLE.
  - Otherwise: idx ← idx-1; stay in SCAN.
- On every completion, exactly one of `ab_out[2:0]` is set. `ab_out[3]` is set only if the decision occurred with idx≠0.
- `ab_out` holds its value until the next completion or reset.
- `enable` in SCAN is ignored; operands and mode are frozen at capture.
- `data_in` and `mode` are don't-care outside the capture edge.

## Timing
- Reset (edge with `rst`=1): state IDLE, `busy`=0, `done_compc`=0, `ab_out`=4'b0000, internal operand/idx registers cleared.
- Reset has priority over `enable` and over an in-progress scan. A mid-scan reset aborts the operation; no `done_compc` is produced.
- Cycle numbering: E0 is the edge sampling `enable`=1 in IDLE. The decision is made at edge Ek, where k is the number of slices scanned (1 ≤ k ≤ N).
- `busy` is high after E0 through Ek. `done_compc` and the new `ab_out` are visible after Ek for exactly one cycle (`done_compc` only).
- Latency from capture to done: k cycles; worst case N (equal operands or difference only in slice 0).
- `done_compc` is low in all other cycles.
- Back-to-back: state is IDLE after Ek, so `enable` sampled at Ek+1 (the `done_compc` cycle) starts a new operation. Throughput is one comparison per k+1 cycles.

## Configuration
- `COMPC_SIGNED_EN` defined: `mode`=1 selects signed comparison via MSB inversion at capture.
- Not defined: the `mode` port remains present but is ignored; all comparisons are unsigned and the MSB-inversion logic is not compiled.

## Test plan
All cases use WIDTH=8, STEP=2 (N=4).
- A=0x5A, B=0x5A, mode=0: `busy` high 4 cycles; `done_compc` pulse after E4; `ab_out`=4'b0001.
- A=0x80, B=0x7F, mode=0: decision at E1; `ab_out`=4'b1100 (gt, early); `busy` low after E1.
- A=0x80, B=0x7F, mode=1:
  - with `COMPC_SIGNED_EN`: `ab_out`=4'b1010 (lt, early) at E1;
  - without it: `ab_out`=4'b1100.
- A=0x03, B=0x02, mode=0: decision at E4; `ab_out`=4'b0100, early bit 0.
- Hold `enable`=1 during a scan while changing `data_in` to 0x0000: result reflects the captured operands only. A new operation starts at the `done_compc` cycle, and its result is `ab_out`=4'b0001 at its E4.
- Assert `rst` at E2 of a scan of A=0x00, B=0x01: after that edge `busy`=0 and `ab_out`=0, and `done_compc` stays 0 for ≥ 5 following cycles.
